// File: rtl/uart_in_pkg.sv
// Shared types for the UART-in feeder: character type, "no data" byte and EOF states.
package uart_in_pkg;

    typedef logic [7:0] uart_char_t;

    localparam uart_char_t UART_EMPTY_CH = 8'hff;

    typedef enum logic [1:0] {
        FEED,
        DRAIN,
        DONE
    } feed_state_e;

endpackage

// File: rtl/uart_in_feeder_if.sv
// Host-push and SoC-read handshake bundle for the UART-in feeder.
// The master is the host/SoC side; the slave is the feeder.
interface uart_in_feeder_if;
    import uart_in_pkg::*;

    logic       host_valid;
    uart_char_t host_ch;
    logic       host_ready;
    logic       host_eof;
    logic       uart_in_valid;
    uart_char_t uart_in_ch;

    modport master (
        output host_valid,
        output host_ch,
        output host_eof,
        output uart_in_valid,
        input  host_ready,
        input  uart_in_ch
    );

    modport slave (
        input  host_valid,
        input  host_ch,
        input  host_eof,
        input  uart_in_valid,
        output host_ready,
        output uart_in_ch
    );

endinterface

// File: rtl/uart_in_fifo.sv
// First-word-fall-through character FIFO; the head entry is visible with zero latency
// and an empty FIFO presents EMPTY_CH.
module uart_in_fifo
    import uart_in_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter uart_char_t EMPTY_CH = UART_EMPTY_CH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  uart_char_t             wr_data,
    output uart_char_t             rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];

    uart_char_t       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    assign rd_data = empty ? EMPTY_CH : mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (pop_ok) begin
            head_d = head_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[tail_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_in_feeder.sv
// Feeds host console characters to the SoC UART-in port and tracks end-of-input.
// Optional macro UART_IN_ECHO_EN adds a registered echo of every delivered character.
module uart_in_feeder
    import uart_in_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter uart_char_t EMPTY_CH = UART_EMPTY_CH
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_in_feeder_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            delivered,
    output logic                   drained
`ifdef UART_IN_ECHO_EN
    ,
    output logic                   echo_valid,
    output uart_char_t             echo_ch
`endif
);

    localparam logic [$clog2(DEPTH):0] CNT_ONE = 1;

    feed_state_e state_q;
    logic        drained_q;
    logic [31:0] delivered_q, delivered_d;
    logic        fifo_full;
    logic        fifo_empty;
    uart_char_t  rd_data;
    logic        push;
    logic        pop;
    logic        next_empty;

    assign bus.host_ready = !fifo_full && (state_q == FEED);
    assign push           = bus.host_valid && bus.host_ready;
    assign pop            = bus.uart_in_valid && !fifo_empty;
    assign bus.uart_in_ch = rd_data;
    assign delivered      = delivered_q;
    assign drained        = drained_q;

    // Occupancy after this edge is zero: either nothing arrives into an empty FIFO,
    // or the last entry leaves with no push alongside it.
    assign next_empty = !push && (fifo_empty || (pop && (fifo_count == CNT_ONE)));

    uart_in_fifo #(
        .DEPTH    (DEPTH),
        .EMPTY_CH (EMPTY_CH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.host_ch),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        delivered_d = delivered_q;
        if (pop) begin
            delivered_d = delivered_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            delivered_q <= '0;
        end else begin
            delivered_q <= delivered_d;
        end
    end

    // An EOF that leaves nothing behind skips DRAIN, otherwise DRAIN would never see a pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= FEED;
            drained_q <= 1'b0;
        end else begin
            case (state_q)
                FEED: begin
                    if (bus.host_eof) begin
                        if (next_empty) begin
                            state_q   <= DONE;
                            drained_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && next_empty) begin
                        state_q   <= DONE;
                        drained_q <= 1'b1;
                    end
                end
                DONE: begin
                    drained_q <= 1'b1;
                end
                default: begin
                    state_q   <= FEED;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_IN_ECHO_EN
    logic       echo_valid_q, echo_valid_d;
    uart_char_t echo_ch_q, echo_ch_d;

    always_comb begin
        echo_valid_d = pop;
        echo_ch_d    = echo_ch_q;
        if (pop) begin
            echo_ch_d = rd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            echo_valid_q <= 1'b0;
            echo_ch_q    <= '0;
        end else begin
            echo_valid_q <= echo_valid_d;
            echo_ch_q    <= echo_ch_d;
        end
    end

    assign echo_valid = echo_valid_q;
    assign echo_ch    = echo_ch_q;
`endif

endmodule

// File: tb/tb_uart_in_feeder.sv
// Scoreboard bench for uart_in_feeder; with UART_IN_ECHO_EN defined it also checks the echo port.
module tb_uart_in_feeder;
    import uart_in_pkg::*;

    localparam int DEPTH = 16;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [31:0]            delivered;
    logic                   drained;
`ifdef UART_IN_ECHO_EN
    logic                   echo_valid;
    uart_char_t             echo_ch;
`endif

    uart_in_feeder_if bus();

    uart_in_feeder #(
        .DEPTH    (DEPTH),
        .EMPTY_CH (8'hff)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .fifo_count (fifo_count),
        .delivered  (delivered),
        .drained    (drained)
`ifdef UART_IN_ECHO_EN
        ,
        .echo_valid (echo_valid),
        .echo_ch    (echo_ch)
`endif
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    uart_char_t  sb[$];
    int          model_state = 0;
    logic [31:0] model_delivered = '0;
    logic        last_pop = 1'b0;
    uart_char_t  last_pop_ch = '0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkState();
        uart_char_t head_ch;
        head_ch = (sb.size() == 0) ? 8'hff : sb[0];
        checkOutput("fifo_count", 32'(fifo_count), 32'(sb.size()));
        checkOutput("delivered", delivered, model_delivered);
        checkOutput("drained", 32'(drained), (model_state == 2) ? 32'd1 : 32'd0);
        checkOutput("host_ready", 32'(bus.host_ready),
                    (sb.size() < DEPTH && model_state == 0) ? 32'd1 : 32'd0);
        checkOutput("uart_in_ch_head", 32'(bus.uart_in_ch), 32'(head_ch));
`ifdef UART_IN_ECHO_EN
        checkOutput("echo_valid", 32'(echo_valid), 32'(last_pop));
        if (last_pop) begin
            checkOutput("echo_ch", 32'(echo_ch), 32'(last_pop_ch));
            $display("[TB] echo 0x%02h '%c'", echo_ch, echo_ch);
        end
`endif
    endtask

    // One clock of stimulus: a request is checked before the edge, the model advances after it.
    task automatic applyStimulus(input logic hv, input uart_char_t hc, input logic eof, input logic rd);
        logic       will_push;
        logic       will_pop;
        uart_char_t exp_ch;
        bus.host_valid    = hv;
        bus.host_ch       = hc;
        bus.host_eof      = eof;
        bus.uart_in_valid = rd;
        #2;
        will_push = hv && (sb.size() < DEPTH) && (model_state == 0);
        will_pop  = rd && (sb.size() != 0);
        if (rd) begin
            exp_ch = (sb.size() == 0) ? 8'hff : sb[0];
            checkOutput("uart_in_ch", 32'(bus.uart_in_ch), 32'(exp_ch));
        end
        @(posedge clock);
        #1;
        if (will_pop) begin
            last_pop_ch = sb.pop_front();
            model_delivered++;
        end
        last_pop = will_pop;
        if (will_push) begin
            sb.push_back(hc);
        end
        case (model_state)
            0: if (eof) model_state = (sb.size() == 0) ? 2 : 1;
            1: if (sb.size() == 0) model_state = 2;
            default: ;
        endcase
        bus.host_valid    = 1'b0;
        bus.host_eof      = 1'b0;
        bus.uart_in_valid = 1'b0;
        checkState();
    endtask

    task automatic doReset();
        bus.host_valid    = 1'b0;
        bus.host_ch       = '0;
        bus.host_eof      = 1'b0;
        bus.uart_in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        sb.delete();
        model_state     = 0;
        model_delivered = '0;
        last_pop        = 1'b0;
        checkState();
    endtask

    initial begin
        bus.host_valid    = 1'b0;
        bus.host_ch       = '0;
        bus.host_eof      = 1'b0;
        bus.uart_in_valid = 1'b0;
        @(posedge clock);
        #1;
        doReset();

        $display("[TB] requests while empty");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("[TB] push 'h','i' then read back");
        applyStimulus(1'b1, 8'h68, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h69, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("delivered_hi", delivered, 32'd2);

        $display("[TB] fill to full, held push, wrap drain");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("full_count", 32'(fifo_count), 32'd16);
        checkOutput("full_ready", 32'(bus.host_ready), 32'd0);
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        checkOutput("refill_count", 32'(fifo_count), 32'd16);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("last_before_wrap_end", 32'(bus.uart_in_ch), 32'h10);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("[TB] push and request together while empty");
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("[TB] eof with pending data");
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("drained_after_eof", 32'(drained), 32'd1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("[TB] reset mid-operation");
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
        doReset();
        checkOutput("reset_ch", 32'(bus.uart_in_ch), 32'hff);

        $display("[TB] eof while empty");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
